// File: rtl/imem_responder.sv
// Instruction-memory responder: word-addressed store with a side load port, serving
// fetch requests over valid/ready request/response channels after a fixed latency.
module imem_responder #(
  parameter logic [63:0] ADDR_BASE   = 64'h0000_0000_8000_0000,
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter int unsigned LATENCY     = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           req_valid_i,
  output logic                           req_ready_o,
  input  logic [63:0]                    req_addr_i,
  output logic                           rsp_valid_o,
  input  logic                           rsp_ready_i,
  output logic [31:0]                    rsp_inst_o,
  output logic                           rsp_err_o,
  input  logic                           load_we_i,
  input  logic [$clog2(DEPTH_WORDS)-1:0] load_idx_i,
  input  logic [31:0]                    load_data_i
);

  localparam int unsigned IW       = $clog2(DEPTH_WORDS);
  localparam logic [63:0] SPAN     = 64'(DEPTH_WORDS) << 2;
  localparam logic [2:0]  CNT_INIT = (LATENCY > 1) ? 3'(LATENCY - 2) : 3'd0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state, state_n;
  logic [2:0]  cnt, cnt_n;
  logic        accept;
  logic        fault;
  logic [63:0] off;
  logic [IW-1:0] idx;

  logic [31:0] mem [DEPTH_WORDS];

  // Unsigned compare against the base avoids aliasing when the subtraction wraps.
  assign off   = req_addr_i - ADDR_BASE;
  assign fault = (|req_addr_i[1:0]) | (req_addr_i < ADDR_BASE) | (off >= SPAN);
  assign idx   = off[IW+1:2];

  always_ff @(posedge clk) begin
    if (load_we_i) mem[load_idx_i] <= load_data_i;
  end

  always_comb begin
    req_ready_o = (state == IDLE) | ((state == RESP) & rsp_ready_i);
    accept      = req_valid_i & req_ready_o;
    state_n     = state;
    cnt_n       = cnt;
    case (state)
      IDLE: ;
      WAIT: begin
        if (cnt == 3'd0) state_n = RESP;
        else             cnt_n   = cnt - 3'd1;
      end
      RESP: if (rsp_ready_i) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (accept) begin
      if (LATENCY == 1) begin
        state_n = RESP;
      end else begin
        state_n = WAIT;
        cnt_n   = CNT_INIT;
      end
    end
  end

  assign rsp_valid_o = (state == RESP);

  // The result register samples mem before the same-edge load lands (read-before-write).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      rsp_inst_o <= '0;
      rsp_err_o  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (accept) begin
        rsp_inst_o <= fault ? '0 : mem[idx];
        rsp_err_o  <= fault;
      end
    end
  end

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder: LATENCY=1 and LATENCY=4 instances share the load
// port; a negedge monitor scores every response handshake against a queue of expectations.
module tb_imem_responder;

  localparam logic [63:0] BASE = 64'h0000_0000_8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        sel;
  logic        req_valid, rsp_ready, load_we;
  logic [63:0] req_addr;
  logic [11:0] load_idx;
  logic [31:0] load_data;

  logic        rr1, rv1, re1, rr4, rv4, re4;
  logic [31:0] ri1, ri4;
  logic        rr, rv, re;
  logic [31:0] ri;

  int checks = 0;
  int errors = 0;

  logic [31:0] model_mem [4096];
  logic [32:0] q [$];

  always #5 clk = ~clk;

  imem_responder #(.LATENCY(1)) u1 (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid & ~sel), .req_ready_o(rr1), .req_addr_i(req_addr),
    .rsp_valid_o(rv1), .rsp_ready_i(rsp_ready), .rsp_inst_o(ri1), .rsp_err_o(re1),
    .load_we_i(load_we), .load_idx_i(load_idx), .load_data_i(load_data)
  );

  imem_responder #(.LATENCY(4)) u4 (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid & sel), .req_ready_o(rr4), .req_addr_i(req_addr),
    .rsp_valid_o(rv4), .rsp_ready_i(rsp_ready), .rsp_inst_o(ri4), .rsp_err_o(re4),
    .load_we_i(load_we), .load_idx_i(load_idx), .load_data_i(load_data)
  );

  assign rr = sel ? rr4 : rr1;
  assign rv = sel ? rv4 : rv1;
  assign ri = sel ? ri4 : ri1;
  assign re = sel ? re4 : re1;

  function automatic logic [32:0] expect_of(input logic [63:0] a);
    logic [63:0] o;
    o = a - BASE;
    if (a[1:0] != 2'b00 || a < BASE || o >= 64'd16384) return {1'b1, 32'h0};
    return {1'b0, model_mem[o[13:2]]};
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      q.delete();
    end else begin
      if (req_valid && rr) q.push_back(expect_of(req_addr));
      if (rv && rsp_ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL rsp_unexpected: got err=%b inst=%h expected no response", re, ri);
        end else begin
          logic [32:0] e;
          e = q.pop_front();
          assert ({re, ri} === e) else begin
            errors++;
            $error("FAIL rsp_data: got %h expected %h", {re, ri}, e);
          end
        end
      end
      if (load_we) model_mem[load_idx] = load_data;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [11:0] i, input logic [31:0] d);
    load_we = 1'b1; load_idx = i; load_data = d;
    cyc();
    load_we = 1'b0;
  endtask

  task automatic wait_rsp;
    int n;
    n = 0;
    @(negedge clk);
    while (!rv && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("rsp_timeout", {63'd0, rv}, 64'd1);
    cyc();
  endtask

  task automatic req_wait(input logic [63:0] a);
    req_valid = 1'b1; req_addr = a;
    cyc();
    req_valid = 1'b0;
    wait_rsp();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] held;
    for (int i = 0; i < 4096; i++) model_mem[i] = 32'h0;
    rst = 1'b0; sel = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1; load_we = 1'b0;
    req_addr = '0; load_idx = '0; load_data = '0;

    repeat (2) @(negedge clk);
    chk("rst_valid1", {63'd0, rv1}, 64'd0);
    chk("rst_inst1", {32'd0, ri1}, 64'd0);
    chk("rst_err1", {63'd0, re1}, 64'd0);
    chk("rst_valid4", {63'd0, rv4}, 64'd0);
    chk("rst_inst4", {32'd0, ri4}, 64'd0);
    chk("rst_err4", {63'd0, re4}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_ready1", {63'd0, rr1}, 64'd1);
    chk("rst_ready4", {63'd0, rr4}, 64'd1);
    cyc();

    load(12'd0, 32'h0000_0413);
    load(12'd1, 32'h0010_0073);
    load(12'd3, 32'hAAAA_AAAA);
    load(12'd4095, 32'hDEAD_BEEF);

    // LATENCY=1 back-to-back
    sel = 1'b0; rsp_ready = 1'b1;
    req_valid = 1'b1; req_addr = BASE;
    @(negedge clk);
    chk("b2b_ready0", {63'd0, rr}, 64'd1);
    cyc();
    req_addr = BASE + 64'd4;
    @(negedge clk);
    chk("b2b_valid0", {63'd0, rv}, 64'd1);
    chk("b2b_inst0", {32'd0, ri}, 64'h0000_0413);
    chk("b2b_ready1", {63'd0, rr}, 64'd1);
    cyc();
    req_valid = 1'b0;
    @(negedge clk);
    chk("b2b_valid1", {63'd0, rv}, 64'd1);
    chk("b2b_inst1", {32'd0, ri}, 64'h0010_0073);
    cyc();
    @(negedge clk);
    chk("b2b_idle", {63'd0, rv}, 64'd0);
    cyc();

    // Faults and range boundaries
    req_wait(BASE + 64'd2);
    chk("mis_err_hold", {63'd0, re}, 64'd1);
    chk("mis_inst_hold", {32'd0, ri}, 64'd0);
    req_wait(64'h0000_0000_7FFF_FFFC);
    req_wait(BASE + 64'd16384);
    req_wait(BASE + 64'd16380);
    chk("last_word_err", {63'd0, re}, 64'd0);
    req_wait(64'hFFFF_FFFF_8000_0000);

    // Same-edge read/write collision on idx 3
    req_valid = 1'b1; req_addr = BASE + 64'd12;
    load_we = 1'b1; load_idx = 12'd3; load_data = 32'h5555_5555;
    cyc();
    req_valid = 1'b0; load_we = 1'b0;
    wait_rsp();
    chk("collide_old", {32'd0, ri}, 64'hAAAA_AAAA);
    req_wait(BASE + 64'd12);
    chk("collide_new", {32'd0, ri}, 64'h5555_5555);

    // LATENCY=4 timing with response backpressure
    sel = 1'b1; rsp_ready = 1'b0;
    req_valid = 1'b1; req_addr = BASE;
    @(negedge clk);
    chk("l4_accept", {63'd0, rr}, 64'd1);
    cyc();
    req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("l4_wait_valid", {63'd0, rv}, 64'd0);
      chk("l4_wait_ready", {63'd0, rr}, 64'd0);
      cyc();
    end
    @(negedge clk);
    chk("l4_valid_rise", {63'd0, rv}, 64'd1);
    held = ri;
    chk("l4_inst", {32'd0, ri}, 64'h0000_0413);
    for (int i = 0; i < 5; i++) begin
      cyc();
      @(negedge clk);
      chk("bp_valid", {63'd0, rv}, 64'd1);
      chk("bp_inst", {32'd0, ri}, {32'd0, held});
      chk("bp_ready", {63'd0, rr}, 64'd0);
    end
    cyc();
    rsp_ready = 1'b1; req_valid = 1'b1; req_addr = BASE + 64'd4;
    @(negedge clk);
    chk("bp_accept", {63'd0, rr}, 64'd1);
    cyc();
    req_valid = 1'b0;
    @(negedge clk);
    chk("bp_rewait", {63'd0, rv}, 64'd0);
    wait_rsp();

    // Reset mid-WAIT drops the in-flight request
    req_valid = 1'b1; req_addr = BASE + 64'd4;
    cyc();
    req_valid = 1'b0;
    cyc();
    cyc();
    #2 rst = 1'b0;
    #1;
    chk("rst_mid_valid", {63'd0, rv4}, 64'd0);
    chk("rst_mid_ready", {63'd0, rr4}, 64'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("rst_no_rsp", {63'd0, rv4}, 64'd0);
    end
    chk("rst_post_ready", {63'd0, rr4}, 64'd1);
    cyc();
    req_wait(BASE + 64'd4);
    chk("mem_kept4", {32'd0, ri4}, 64'h0010_0073);
    sel = 1'b0;
    req_wait(BASE + 64'd16380);
    chk("mem_kept1", {32'd0, ri1}, 64'hDEAD_BEEF);

    repeat (3) cyc();
    chk("sb_empty", 64'(q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_responder.md
Name: imem_responder

Overview:
- Instruction-memory responder: the memory-side end of the core's fetch interface.
- Accepts fetch requests (PC) on a valid/ready request channel.
- Returns the 32-bit instruction (or an error) on a valid/ready response channel after a programmable latency.
- Holds a word-addressed instruction store that a bench or loader fills through a side write port; replaces the ideal combinational inst feed so the core and its fetch logic can be exercised against a real handshake.

Parameters:
- ADDR_BASE, 64'h0000_0000_8000_0000, byte address of word 0.
- DEPTH_WORDS, 4096, number of 32-bit instruction words (power of two).
- LATENCY, 1, cycles from request accept to response valid; legal 1..8.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid_i  in  1  fetch request valid.
- req_ready_o  out  1  responder can accept a request this cycle.
- req_addr_i  in  64  fetch byte address (PC).
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  requester accepts the response.
- rsp_inst_o  out  32  fetched instruction.
- rsp_err_o  out  1  access fault (misaligned or out of range).
- load_we_i  in  1  side-port write enable.
- load_idx_i  in  log2(DEPTH_WORDS)  side-port word index.
- load_data_i  in  32  side-port write data.

Behaviour:
- Reset (rst=0, asynchronous):
  - Outputs: rsp_valid_o=0, rsp_inst_o=0, rsp_err_o=0.
  - State=IDLE, latency counter=0, so req_ready_o=1 once rst is released.
  - Memory contents are not reset.
  - Reset mid-WAIT or mid-RESP drops the in-flight request. No response is ever produced for it.
- States:
  - IDLE: no request outstanding.
  - WAIT: counting down latency.
  - RESP: response held on the outputs.
- req_ready_o is combinational: req_ready_o = (state==IDLE) | (state==RESP & rsp_ready_i). At most one request is outstanding.
- Accept = req_valid_i & req_ready_o. On accept at edge T:
  - Decode the address:
    - idx = (req_addr_i - ADDR_BASE) >> 2.
    - misaligned = req_addr_i[1:0] != 0.
    - out of range = req_addr_i < ADDR_BASE, or (req_addr_i - ADDR_BASE) >= 4*DEPTH_WORDS.
    - 64-bit subtraction; the comparison is unsigned, so no wrap-around aliasing.
  - Capture the result register at T:
    - If the address is legal: inst = mem[idx], err = 0.
    - If the address is faulting: inst = 32'h0000_0000, err = 1.
  - If LATENCY==1: next state RESP. rsp_valid_o=1 in the cycle after T.
  - Else: next state WAIT, counter=LATENCY-2.
- WAIT:
  - Decrement the counter each cycle.
  - When counter==0, go to RESP.
  - rsp_valid_o rises exactly LATENCY cycles after the accept edge.
- RESP:
  - rsp_valid_o=1. rsp_inst_o and rsp_err_o are stable until the handshake.
  - On rsp_valid_o & rsp_ready_i:
    - If a new request is accepted in the same cycle, its result replaces the output register and the new-request rules above apply. For LATENCY==1, rsp_valid_o stays high (back-to-back, one response per cycle).
    - Otherwise go to IDLE, rsp_valid_o=0, and rsp_inst_o/rsp_err_o hold their last values.
- rsp_valid_o is never withdrawn without a handshake, except by reset.
- Side port:
  - mem[load_idx_i] <= load_data_i on the clk edge when load_we_i=1, independent of FSM state.
  - Same-edge collision with an accepted read of the same idx: the read returns the OLD word (read-before-write).
  - A write during WAIT/RESP to the pending word does not alter the captured response.
- req_addr_i is ignored when no accept occurs. No X on outputs after reset.

Test Plan:
- Reset, then load mem[0]=32'h0000_0413 and mem[1]=32'h0010_0073. LATENCY=1, rsp_ready_i=1, request 0x8000_0000 then 0x8000_0004 back-to-back -> rsp_inst 0x00000413 then 0x00100073 on consecutive cycles, err=0, req_ready_o held 1.
- LATENCY=4, single request 0x8000_0000 accepted at edge T -> rsp_valid_o first high at T+4, req_ready_o=0 during WAIT.
- Response backpressure: rsp_ready_i=0 for 5 cycles -> rsp_valid_o/rsp_inst_o stable, req_ready_o=0. Raise rsp_ready_i with req_valid_i=1 -> handshake and accept in the same cycle.
- Faults: request 0x8000_0002 -> err=1, inst=0. Request 0x7FFF_FFFC -> err=1. Request ADDR_BASE+4*DEPTH_WORDS -> err=1. Request ADDR_BASE+4*(DEPTH_WORDS-1) -> err=0 and the loaded word.
- Collision: same edge accept read idx 3 (old 0xAAAA_AAAA) and load_we idx 3 = 0x5555_5555 -> response 0xAAAA_AAAA. The next read of idx 3 returns 0x5555_5555.
- Reset asserted mid-WAIT (LATENCY=4, 2 cycles in) -> rsp_valid_o=0 immediately, no response after release, req_ready_o=1, and earlier-loaded memory still intact.
